// File: rtl/decode_stage.sv
// Decode stage: main/ALU decoders, immediate extension, 32x32 register file and the ID/EX register.
// Optional macro RF_BYPASS_EN forwards a same-cycle writeback to the read ports.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCplus4D,
    input  logic        FlushE,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic [31:0] PCE,
    output logic [31:0] PCplus4E
);

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    logic [6:0]  op_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_s, rs2_s, rd_s;
    logic        reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
    logic [1:0]  result_src_d, imm_src_s, alu_op_s;
    logic [2:0]  alu_control_d;
    logic [31:0] imm_ext_d, rd1_d, rd2_d;
    logic [31:0] rf_q [32];

    logic        reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q;
    logic [1:0]  result_src_q;
    logic [2:0]  alu_control_q;
    logic [31:0] rd1_q, rd2_q, imm_ext_q, pc_q, pc_plus4_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;

    assign op_s     = instrD[6:0];
    assign funct3_s = instrD[14:12];
    assign rd_s     = instrD[11:7];
    assign rs1_s    = instrD[19:15];
    assign rs2_s    = instrD[24:20];

    // Main decoder: unrecognised opcodes leave every control bit low (bubble).
    always_comb begin
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        jump_d       = 1'b0;
        branch_d     = 1'b0;
        alu_src_d    = 1'b0;
        result_src_d = 2'b00;
        imm_src_s    = IMM_I;
        alu_op_s     = 2'b00;
        case (op_s)
            7'b0000011: begin reg_write_d = 1'b1; alu_src_d = 1'b1; result_src_d = 2'b01; end
            7'b0100011: begin mem_write_d = 1'b1; alu_src_d = 1'b1; imm_src_s = IMM_S; end
            7'b0110011: begin reg_write_d = 1'b1; alu_op_s = 2'b10; end
            7'b1100011: begin branch_d = 1'b1; imm_src_s = IMM_B; alu_op_s = 2'b01; end
            7'b0010011: begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_op_s = 2'b10; end
            7'b1101111: begin reg_write_d = 1'b1; jump_d = 1'b1; imm_src_s = IMM_J; result_src_d = 2'b10; end
            default: begin reg_write_d = 1'b0; end
        endcase
    end

    // ALU decoder: subtract for R-type with funct7[5] set; I-type funct3=000 is always addi.
    always_comb begin
        alu_control_d = 3'b000;
        case (alu_op_s)
            2'b00: alu_control_d = 3'b000;
            2'b01: alu_control_d = 3'b001;
            2'b10: begin
                case (funct3_s)
                    3'b000: begin
                        if (op_s[5] && instrD[30]) begin
                            alu_control_d = 3'b001;
                        end else begin
                            alu_control_d = 3'b000;
                        end
                    end
                    3'b010: alu_control_d = 3'b101;
                    3'b110: alu_control_d = 3'b011;
                    3'b111: alu_control_d = 3'b010;
                    default: alu_control_d = 3'b000;
                endcase
            end
            default: alu_control_d = 3'b000;
        endcase
    end

    // Immediate extension, sign taken from instrD[31] in every format.
    always_comb begin
        imm_ext_d = 32'h0000_0000;
        case (imm_src_s)
            IMM_I: imm_ext_d = {{20{instrD[31]}}, instrD[31:20]};
            IMM_S: imm_ext_d = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
            IMM_B: imm_ext_d = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
            IMM_J: imm_ext_d = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
            default: imm_ext_d = 32'h0000_0000;
        endcase
    end

    // Register file read ports; x0 is hardwired to zero.
    always_comb begin
        rd1_d = rf_q[rs1_s];
        rd2_d = rf_q[rs2_s];
`ifdef RF_BYPASS_EN
        if (RegWriteW && (RDW != 5'd0) && (RDW == rs1_s)) begin
            rd1_d = ResultW;
        end else begin
            rd1_d = rf_q[rs1_s];
        end
        if (RegWriteW && (RDW != 5'd0) && (RDW == rs2_s)) begin
            rd2_d = ResultW;
        end else begin
            rd2_d = rf_q[rs2_s];
        end
`endif
        if (rs1_s == 5'd0) begin
            rd1_d = 32'h0000_0000;
        end else begin
            rd1_d = rd1_d;
        end
        if (rs2_s == 5'd0) begin
            rd2_d = 32'h0000_0000;
        end else begin
            rd2_d = rd2_d;
        end
    end

    // Register file write port; writes to x0 are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'h0000_0000;
            end
        end else if (RegWriteW && (RDW != 5'd0)) begin
            rf_q[RDW] <= ResultW;
        end
    end

    // ID/EX pipeline register; a flush loads the same bubble as reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || FlushE) begin
            if (!rst || FlushE) begin
                reg_write_q   <= 1'b0;
            end
            mem_write_q   <= 1'b0;
            jump_q        <= 1'b0;
            branch_q      <= 1'b0;
            alu_src_q     <= 1'b0;
            result_src_q  <= 2'b00;
            alu_control_q <= 3'b000;
            rd1_q         <= 32'h0000_0000;
            rd2_q         <= 32'h0000_0000;
            imm_ext_q     <= 32'h0000_0000;
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            rd_q          <= 5'd0;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= 32'h0000_0000;
        end else begin
            reg_write_q   <= reg_write_d;
            mem_write_q   <= mem_write_d;
            jump_q        <= jump_d;
            branch_q      <= branch_d;
            alu_src_q     <= alu_src_d;
            result_src_q  <= result_src_d;
            alu_control_q <= alu_control_d;
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            imm_ext_q     <= imm_ext_d;
            rs1_q         <= rs1_s;
            rs2_q         <= rs2_s;
            rd_q          <= rd_s;
            pc_q          <= PCD;
            pc_plus4_q    <= PCplus4D;
        end
    end

    assign RegWriteE   = reg_write_q;
    assign MemWriteE   = mem_write_q;
    assign JumpE       = jump_q;
    assign BranchE     = branch_q;
    assign ALUSrcE     = alu_src_q;
    assign ResultSrcE  = result_src_q;
    assign ALUControlE = alu_control_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ImmExtE     = imm_ext_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;
    assign PCE         = pc_q;
    assign PCplus4E    = pc_plus4_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised self-checking bench for decode_stage against an instruction-level reference model.
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    typedef struct packed {
        logic        rw, mw, j, br, as;
        logic [1:0]  rs;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  r1, r2, rd;
        logic [31:0] pc, pc4;
    } out_t;

    logic        clk, rst, FlushE, RegWriteW;
    logic [31:0] instrD, PCD, PCplus4D, ResultW;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCplus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    out_t        got_s, exp_s, bubble_s;
    logic [31:0] mrf [32];
    logic [31:0] pc_v;
    int          total, bad;

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .instrD(instrD), .PCD(PCD), .PCplus4D(PCplus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .PCE(PCE), .PCplus4E(PCplus4E)
    );

    assign got_s = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
                    RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCplus4E};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register value as seen by a read in the cycle of a given writeback.
    function automatic logic [31:0] read_reg(input logic [4:0] r, input logic rw,
                                             input logic [4:0] wd, input logic [31:0] res);
        if (r == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (rw && wd == r) return res;
`endif
        return mrf[r];
    endfunction

    // Instruction-level expectation of what the ID/EX register holds after one edge.
    function automatic out_t model(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                                   input logic rw, input logic [4:0] wd, input logic [31:0] res);
        out_t        o;
        logic [11:0] i12, s12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [6:0]  op;
        int          f3;
        if (fl) return bubble_s;
        o   = '0;
        op  = ins[6:0];
        f3  = int'(ins[14:12]);
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        o.imm = 32'($signed(i12));
        o.r1  = ins[19:15];
        o.r2  = ins[24:20];
        o.rd  = ins[11:7];
        o.rd1 = read_reg(o.r1, rw, wd, res);
        o.rd2 = read_reg(o.r2, rw, wd, res);
        o.pc  = pc;
        o.pc4 = pc + 32'd4;
        if (op == 7'h03) begin
            o.rw = 1'b1; o.as = 1'b1; o.rs = 2'd1;
        end else if (op == 7'h23) begin
            o.mw = 1'b1; o.as = 1'b1; o.imm = 32'($signed(s12));
        end else if (op == 7'h63) begin
            o.br = 1'b1; o.alu = 3'd1; o.imm = 32'($signed(b13));
        end else if (op == 7'h6f) begin
            o.rw = 1'b1; o.j = 1'b1; o.rs = 2'd2; o.imm = 32'($signed(j21));
        end else if (op == 7'h33 || op == 7'h13) begin
            o.rw = 1'b1;
            o.as = (op == 7'h13);
            if (f3 == 2) o.alu = 3'd5;
            else if (f3 == 6) o.alu = 3'd3;
            else if (f3 == 7) o.alu = 3'd2;
            else if (f3 == 0 && op == 7'h33 && ins[30]) o.alu = 3'd1;
            else o.alu = 3'd0;
        end
        return o;
    endfunction

    // Apply one cycle of stimulus; exp_s holds the model's prediction, sampled 1 time unit after the edge.
    task automatic cycle(input logic [31:0] ins, input logic fl, input logic rw,
                         input logic [4:0] wd, input logic [31:0] res);
        instrD = ins; PCD = pc_v; PCplus4D = pc_v + 32'd4;
        FlushE = fl; RegWriteW = rw; RDW = wd; ResultW = res;
        exp_s = model(ins, pc_v, fl, rw, wd, res);
        @(posedge clk);
        #1;
        if (rw && wd != 5'd0) mrf[wd] = res;
        pc_v = pc_v + 32'd4;
        RegWriteW = 1'b0; FlushE = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; instrD = 32'h0; PCD = 32'h0; PCplus4D = 32'h0; FlushE = 1'b0;
        RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0; pc_v = 32'h0000_0200;
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (got_s !== bubble_s) begin
            bad++;
            $display("FAIL reset got=%h want=%h", got_s, bubble_s);
        end
        rst = 1'b1;
    endtask

    task automatic test_lw();
        cycle(32'h0284_2903, 1'b0, 1'b0, 5'd0, 32'h0);
        total++;
        if (RegWriteE !== 1'b1 || ResultSrcE !== 2'b01 || ALUSrcE !== 1'b1 || ImmExtE !== 32'h28 ||
            Rs1E !== 5'd8 || RdE !== 5'd18 || RD1E !== 32'h0) begin
            bad++;
            $display("FAIL lw_fields got=%h", got_s);
        end
        total++;
        if (got_s !== exp_s) begin bad++; $display("FAIL lw got=%h want=%h", got_s, exp_s); end
    endtask

    task automatic test_add();
        cycle(32'h0000_0000, 1'b0, 1'b1, 5'd25, 32'd5);
        cycle(32'h0000_0000, 1'b0, 1'b1, 5'd26, 32'd7);
        cycle(32'h01AC_89B3, 1'b0, 1'b0, 5'd0, 32'h0);
        total++;
        if (ALUControlE !== 3'b000 || RD1E !== 32'd5 || RD2E !== 32'd7 || RdE !== 5'd19 ||
            ALUSrcE !== 1'b0) begin
            bad++;
            $display("FAIL add_fields got=%h", got_s);
        end
        total++;
        if (got_s !== exp_s) begin bad++; $display("FAIL add got=%h want=%h", got_s, exp_s); end
    endtask

    task automatic test_sw();
        cycle(32'h016E_AA23, 1'b0, 1'b0, 5'd0, 32'h0);
        total++;
        if (MemWriteE !== 1'b1 || RegWriteE !== 1'b0 || ImmExtE !== 32'h14 || Rs2E !== 5'd22 ||
            Rs1E !== 5'd29) begin
            bad++;
            $display("FAIL sw_fields got=%h", got_s);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
`ifdef RF_BYPASS_EN
        want = 32'h100;
`else
        want = 32'h0;
`endif
        cycle(32'h0284_2903, 1'b0, 1'b1, 5'd8, 32'h100);
        total++;
        if (RD1E !== want) begin bad++; $display("FAIL bypass got=%h want=%h", RD1E, want); end
        cycle(32'h0284_2903, 1'b0, 1'b0, 5'd0, 32'h0);
        total++;
        if (RD1E !== 32'h100) begin bad++; $display("FAIL bypass_repeat got=%h want=%h", RD1E, 32'h100); end
    endtask

    task automatic test_x0();
        cycle(32'h0000_0000, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        cycle(32'h0000_0093, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        total++;
        if (RD1E !== 32'h0) begin bad++; $display("FAIL x0 got=%h want=%h", RD1E, 32'h0); end
    endtask

    task automatic test_flush();
        cycle(32'h01AC_89B3, 1'b1, 1'b1, 5'd9, 32'h0000_0ABC);
        total++;
        if (got_s !== bubble_s) begin bad++; $display("FAIL flush got=%h want=%h", got_s, bubble_s); end
        cycle(32'h0004_8133, 1'b0, 1'b0, 5'd0, 32'h0);
        total++;
        if (RD1E !== 32'h0000_0ABC) begin bad++; $display("FAIL flush_write got=%h want=%h", RD1E, 32'h0ABC); end
    endtask

    task automatic test_random();
        logic [6:0]  ops [7];
        logic [31:0] ins;
        ops = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6f, 7'h00};
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 6)];
            cycle(ins, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), $urandom);
            total++;
            if (got_s !== exp_s) begin
                bad++;
                $display("FAIL random[%0d] ins=%h got=%h want=%h", n, ins, got_s, exp_s);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(32'h0000_0000, 1'b0, 1'b1, 5'd25, 32'h1234_5678);
        cycle(32'h01AC_89B3, 1'b0, 1'b0, 5'd0, 32'h0);
        #2 rst = 1'b0;
        #1;
        total++;
        if (got_s !== bubble_s) begin bad++; $display("FAIL reset_mid got=%h want=%h", got_s, bubble_s); end
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        @(posedge clk);
        #1 rst = 1'b1;
        cycle(32'h01AC_89B3, 1'b0, 1'b0, 5'd0, 32'h0);
        total++;
        if (RD1E !== 32'h0 || RD2E !== 32'h0 || got_s !== exp_s) begin
            bad++;
            $display("FAIL reset_rf got=%h want=%h", got_s, exp_s);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        bubble_s = '0;
        bubble_s.pc = RST_PC;
        test_reset();
        test_lw();
        test_add();
        test_sw();
        test_bypass();
        test_x0();
        test_flush();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
